// File: rtl/cmos_stream_delay.sv
// Programmable delay line for CMOS pixel streams; delay changes take effect at a frame edge.
// Optional registered vsync edge pulses on the delayed stream: define CMOS_DELAY_EDGE_OUT_EN.
module cmos_stream_delay #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned DLY_W         = 5,
  parameter int unsigned DEFAULT_DELAY = 3
) (
  input  logic                  cmos_pclk,
  input  logic                  rst_n,
  input  logic                  cmos_href,
  input  logic                  cmos_vsync,
  input  logic [DATA_WIDTH-1:0] cmos_data,
  input  logic [DLY_W-1:0]      cfg_delay,
  input  logic                  cfg_update,
  output logic                  cmos_href_delay,
  output logic                  cmos_vsync_delay,
  output logic [DATA_WIDTH-1:0] cmos_data_delay,
  output logic [DLY_W-1:0]      cur_delay,
  output logic                  cfg_busy,
  output logic                  fill_done
`ifdef CMOS_DELAY_EDGE_OUT_EN
  ,
  output logic                  vsync_rise_o,
  output logic                  vsync_fall_o
`endif
);

  localparam int unsigned PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int unsigned ENT_W = DATA_WIDTH + 2;
  localparam int unsigned IDX_W = DLY_W + 1;
  localparam logic [DLY_W-1:0] MaxDly  = DLY_W'(MAX_DELAY);
  localparam logic [PTR_W-1:0] LastPtr = PTR_W'(MAX_DELAY - 1);

  typedef enum logic [1:0] {StIdle, StPending, StFlush} state_e;

  state_e           r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [DLY_W-1:0] r_cur_delay;
  logic [DLY_W-1:0] r_fill_cnt;
  logic [DLY_W-1:0] r_pending;
  logic             r_pend_vld;
  logic             r_vsync_prev;
  logic [ENT_W-1:0] r_buf [MAX_DELAY];

  logic [DLY_W-1:0] w_cfg_sat;
  logic [DLY_W-1:0] w_apply_dly;
  logic [DLY_W-1:0] w_fill_inc;
  logic             w_vsync_rise;
  logic             w_fill_done;
  logic [IDX_W-1:0] w_rd_sum;
  logic [IDX_W-1:0] w_rd_idx;
  logic [ENT_W-1:0] w_entry;
  logic [ENT_W-1:0] w_out;

  assign w_cfg_sat    = (cfg_delay > MaxDly) ? MaxDly : cfg_delay;
  assign w_apply_dly  = cfg_update ? w_cfg_sat : r_pending;
  assign w_fill_inc   = r_fill_cnt + 1'b1;
  assign w_vsync_rise = cmos_vsync & ~r_vsync_prev;
  assign w_fill_done  = (r_fill_cnt == r_cur_delay);

  // Read index (wr_ptr - d) mod MAX_DELAY without needing a power-of-two depth.
  always_comb begin
    w_rd_sum = IDX_W'(r_wr_ptr) + IDX_W'(MAX_DELAY) - IDX_W'(r_cur_delay);
    w_rd_idx = (w_rd_sum >= IDX_W'(MAX_DELAY)) ? (w_rd_sum - IDX_W'(MAX_DELAY)) : w_rd_sum;
  end

  always_comb begin
    w_entry = r_buf[PTR_W'(w_rd_idx)];
    if (r_cur_delay == '0) begin
      w_entry = {cmos_vsync, cmos_href, cmos_data};
    end
    w_out = (rst_n && w_fill_done) ? w_entry : '0;
  end

  assign cmos_vsync_delay = w_out[ENT_W-1];
  assign cmos_href_delay  = w_out[ENT_W-2];
  assign cmos_data_delay  = w_out[DATA_WIDTH-1:0];
  assign cur_delay        = rst_n ? r_cur_delay : '0;
  assign cfg_busy         = rst_n && (r_state != StIdle);
  assign fill_done        = rst_n && w_fill_done;

  always_ff @(posedge cmos_pclk) begin
    r_buf[r_wr_ptr] <= {cmos_vsync, cmos_href, cmos_data};
  end

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_wr_ptr     <= '0;
      r_cur_delay  <= DLY_W'(DEFAULT_DELAY);
      r_fill_cnt   <= '0;
      r_pending    <= '0;
      r_pend_vld   <= 1'b0;
      r_vsync_prev <= 1'b0;
    end else begin
      r_wr_ptr     <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
      r_vsync_prev <= cmos_vsync;
      if (r_fill_cnt != r_cur_delay) begin
        r_fill_cnt <= w_fill_inc;
      end
      unique case (r_state)
        StIdle: begin
          if (cfg_update) begin
            r_pending <= w_cfg_sat;
            r_state   <= StPending;
          end
        end
        StPending: begin
          if (w_vsync_rise) begin
            r_cur_delay <= w_apply_dly;
            r_fill_cnt  <= '0;
            // A zero delay needs no refill, so skip the flush entirely.
            r_state     <= (w_apply_dly == '0) ? StIdle : StFlush;
          end else if (cfg_update) begin
            r_pending <= w_cfg_sat;
          end
        end
        StFlush: begin
          if (cfg_update) begin
            r_pending <= w_cfg_sat;
          end
          // Leave on the edge that completes the fill so busy drops as fill_done rises.
          if (w_fill_inc == r_cur_delay) begin
            r_state    <= (r_pend_vld || cfg_update) ? StPending : StIdle;
            r_pend_vld <= 1'b0;
          end else if (cfg_update) begin
            r_pend_vld <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef CMOS_DELAY_EDGE_OUT_EN
  logic r_vsd_prev;
  logic r_vs_rise;
  logic r_vs_fall;

  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      r_vsd_prev <= 1'b0;
      r_vs_rise  <= 1'b0;
      r_vs_fall  <= 1'b0;
    end else begin
      r_vsd_prev <= cmos_vsync_delay;
      r_vs_rise  <= cmos_vsync_delay & ~r_vsd_prev;
      r_vs_fall  <= ~cmos_vsync_delay & r_vsd_prev;
    end
  end

  assign vsync_rise_o = rst_n & r_vs_rise;
  assign vsync_fall_o = rst_n & r_vs_fall;
`endif

endmodule

// File: tb/tb_cmos_stream_delay.sv
// Bench for cmos_stream_delay: cycle-indexed history model plus directed literal checks.
module tb_cmos_stream_delay;

  localparam int MAXD = 16;
  localparam int DEFD = 3;

  logic       cmos_pclk = 1'b0;
  logic       rst_n;
  logic       cmos_href;
  logic       cmos_vsync;
  logic [7:0] cmos_data;
  logic [4:0] cfg_delay;
  logic       cfg_update;
  logic       cmos_href_delay;
  logic       cmos_vsync_delay;
  logic [7:0] cmos_data_delay;
  logic [4:0] cur_delay;
  logic       cfg_busy;
  logic       fill_done;
`ifdef CMOS_DELAY_EDGE_OUT_EN
  logic       vsync_rise_o;
  logic       vsync_fall_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  cmos_stream_delay #(
    .DATA_WIDTH   (8),
    .MAX_DELAY    (16),
    .DLY_W        (5),
    .DEFAULT_DELAY(3)
  ) dut (
    .cmos_pclk       (cmos_pclk),
    .rst_n           (rst_n),
    .cmos_href       (cmos_href),
    .cmos_vsync      (cmos_vsync),
    .cmos_data       (cmos_data),
    .cfg_delay       (cfg_delay),
    .cfg_update      (cfg_update),
    .cmos_href_delay (cmos_href_delay),
    .cmos_vsync_delay(cmos_vsync_delay),
    .cmos_data_delay (cmos_data_delay),
    .cur_delay       (cur_delay),
    .cfg_busy        (cfg_busy),
    .fill_done       (fill_done)
`ifdef CMOS_DELAY_EDGE_OUT_EN
    ,
    .vsync_rise_o    (vsync_rise_o),
    .vsync_fall_o    (vsync_fall_o)
`endif
  );

  always #5 cmos_pclk = ~cmos_pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_dly(input logic [4:0] d);
    return (int'(d) > MAXD) ? MAXD : int'(d);
  endfunction

  // Model: remembers every input by absolute cycle number; a delay d applied so that
  // refill starts at cycle s makes cycle t valid once t-s >= d, showing the input of t-d.
  logic [9:0] hist [64];
  int  m_t        = 0;
  int  m_start    = 0;
  int  m_delay    = DEFD;
  int  m_pend_val = 0;
  bit  m_valid    = 1'b0;
  bit  m_in_flush = 1'b0;
  bit  m_pend_vld = 1'b0;
  bit  m_vprev    = 1'b0;

  always @(posedge cmos_pclk) begin
    m_valid           <= 1'b1;
    hist[m_t % 64]    <= {cmos_vsync, cmos_href, cmos_data};
    m_t               <= m_t + 1;
    if (!rst_n) begin
      m_delay    <= DEFD;
      m_start    <= m_t + 1;
      m_in_flush <= 1'b0;
      m_pend_vld <= 1'b0;
      m_pend_val <= 0;
      m_vprev    <= 1'b0;
    end else begin
      m_vprev <= cmos_vsync;
      if (m_pend_vld && cmos_vsync && !m_vprev && !(m_in_flush && (m_t - m_start) < m_delay)) begin
        m_delay    <= cfg_update ? sat_dly(cfg_delay) : m_pend_val;
        m_start    <= m_t + 1;
        m_in_flush <= 1'b1;
        m_pend_vld <= 1'b0;
      end else if (cfg_update) begin
        m_pend_vld <= 1'b1;
        m_pend_val <= sat_dly(cfg_delay);
      end
    end
  end

  logic [16:0] e_vec;
  logic [9:0]  e_ent;
  logic        e_fill;
  logic        e_busy;
  logic        e_vsd_now = 1'b0;

  always @(negedge cmos_pclk) begin
    if (m_valid) begin
      e_vec = '0;
      if (rst_n) begin
        e_fill = (m_t - m_start) >= m_delay;
        e_busy = m_pend_vld || (m_in_flush && !e_fill);
        if (!e_fill)           e_ent = '0;
        else if (m_delay == 0) e_ent = {cmos_vsync, cmos_href, cmos_data};
        else                   e_ent = hist[(m_t - m_delay) % 64];
        e_vec = {e_ent, 5'(m_delay), e_busy, e_fill};
      end
      e_vsd_now = e_vec[16];
      check("cycle_outputs", 32'({cmos_vsync_delay, cmos_href_delay, cmos_data_delay, cur_delay,
                                  cfg_busy, fill_done}), 32'(e_vec));
`ifdef CMOS_DELAY_EDGE_OUT_EN
      check("edge_pulses", 32'({vsync_rise_o, vsync_fall_o}),
            rst_n ? 32'({e_rise, e_fall}) : 32'd0);
`endif
    end
  end

`ifdef CMOS_DELAY_EDGE_OUT_EN
  logic e_rise = 1'b0;
  logic e_fall = 1'b0;
  logic e_vsd_prev = 1'b0;
  always @(posedge cmos_pclk) begin
    if (!rst_n) begin
      e_rise     <= 1'b0;
      e_fall     <= 1'b0;
      e_vsd_prev <= 1'b0;
    end else begin
      e_rise     <= e_vsd_now & ~e_vsd_prev;
      e_fall     <= ~e_vsd_now & e_vsd_prev;
      e_vsd_prev <= e_vsd_now;
    end
  end
`endif

  task automatic set_in(input logic vs, input logic upd, input logic [4:0] cd);
    cmos_href  = ((cyc % 8) != 7);
    cmos_vsync = vs;
    cfg_update = upd;
    cfg_delay  = cd;
    cmos_data  = 8'(cyc);
  endtask

  task automatic nxt();
    @(posedge cmos_pclk);
    #1;
    cyc++;
  endtask

  task automatic step(input logic vs, input logic upd, input logic [4:0] cd);
    set_in(vs, upd, cd);
    nxt();
  endtask

  task automatic neg();
    @(negedge cmos_pclk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 5'd0);
    @(posedge cmos_pclk);
    #1;
    step(1'b0, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("reset_outputs_zero", 32'({cmos_href_delay, cmos_vsync_delay, cmos_data_delay, cur_delay,
                                     cfg_busy, fill_done}), 32'd0);
    nxt();

    // Default delay 3 from reset release.
    rst_n = 1'b1;
    cyc   = 0;
    step(1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c2_fill_low", 32'(fill_done), 32'd0);
    check("c2_data_gated", 32'(cmos_data_delay), 32'd0);
    nxt();
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c3_fill_high", 32'(fill_done), 32'd1);
    check("c3_href_delayed", 32'(cmos_href_delay), 32'd1);
    nxt();
    repeat (4) step(1'b0, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c8_data_lag3", 32'(cmos_data_delay), 32'h05);
    check("c8_cur_default", 32'(cur_delay), 32'd3);
    nxt();

    // Mid-frame request for 7 waits for the next vsync rise.
    set_in(1'b0, 1'b1, 5'd7); neg();
    check("c9_busy_idle", 32'(cfg_busy), 32'd0);
    nxt();
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c10_busy_pending", 32'(cfg_busy), 32'd1);
    check("c10_cur_unchanged", 32'(cur_delay), 32'd3);
    nxt();
    repeat (5) step(1'b0, 1'b0, 5'd0);
    set_in(1'b1, 1'b0, 5'd0); neg();
    check("c16_cur_before_edge", 32'(cur_delay), 32'd3);
    nxt();
    set_in(1'b1, 1'b0, 5'd0); neg();
    check("c17_cur7", 32'(cur_delay), 32'd7);
    check("c17_fill_low", 32'(fill_done), 32'd0);
    check("c17_busy", 32'(cfg_busy), 32'd1);
    nxt();
    repeat (2) step(1'b1, 1'b0, 5'd0);
    repeat (3) step(1'b0, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c23_fill_low", 32'(fill_done), 32'd0);
    check("c23_busy", 32'(cfg_busy), 32'd1);
    nxt();
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c24_fill_high", 32'(fill_done), 32'd1);
    check("c24_busy_drop", 32'(cfg_busy), 32'd0);
    check("c24_data_lag7", 32'(cmos_data_delay), 32'h11);
    nxt();

    // Request 31 saturates to 16; run long enough for several pointer wraps.
    repeat (5) step(1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd31);
    repeat (9) step(1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0);
    set_in(1'b1, 1'b0, 5'd0); neg();
    check("c41_cur_sat16", 32'(cur_delay), 32'd16);
    nxt();
    for (int c = 42; c < 170; c++) begin
      if (c == 150) begin
        set_in(1'b0, 1'b0, 5'd0); neg();
        check("c150_data_lag16", 32'(cmos_data_delay), 32'h86);
        nxt();
      end else begin
        step((c == 42) || (c == 100) || (c == 101), 1'b0, 5'd0);
      end
    end

    // Delay 0: combinational bypass right after the frame edge.
    step(1'b0, 1'b1, 5'd0);
    repeat (5) step(1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0);
    set_in(1'b1, 1'b0, 5'd0); neg();
    check("c177_cur0", 32'(cur_delay), 32'd0);
    check("c177_fill", 32'(fill_done), 32'd1);
    check("c177_busy", 32'(cfg_busy), 32'd0);
    check("c177_bypass_data", 32'(cmos_data_delay), 32'hB1);
    check("c177_bypass_vsync", 32'(cmos_vsync_delay), 32'd1);
    nxt();
    repeat (3) step(1'b0, 1'b0, 5'd0);

    // Update coincident with a rise in IDLE is deferred, then overridden by 9.
    set_in(1'b1, 1'b1, 5'd5); neg();
    check("c181_busy_idle", 32'(cfg_busy), 32'd0);
    nxt();
    set_in(1'b1, 1'b0, 5'd0); neg();
    check("c182_busy", 32'(cfg_busy), 32'd1);
    check("c182_cur_not5", 32'(cur_delay), 32'd0);
    nxt();
    repeat (3) step(1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd9);
    set_in(1'b1, 1'b0, 5'd0); neg();
    check("c187_cur9", 32'(cur_delay), 32'd9);
    check("c187_fill_low", 32'(fill_done), 32'd0);
    nxt();
    step(1'b0, 1'b1, 5'd12);
    step(1'b0, 1'b0, 5'd0);

    // One-cycle reset during flush discards the pending 12.
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c190_reset_zero", 32'({cmos_href_delay, cmos_vsync_delay, cmos_data_delay, cur_delay,
                                   cfg_busy, fill_done}), 32'd0);
    nxt();
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c191_cur_default", 32'(cur_delay), 32'd3);
    check("c191_busy", 32'(cfg_busy), 32'd0);
    check("c191_fill_low", 32'(fill_done), 32'd0);
    nxt();
    repeat (2) step(1'b0, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c194_fill_high", 32'(fill_done), 32'd1);
    check("c194_data_lag3", 32'(cmos_data_delay), 32'hBF);
    nxt();
    step(1'b1, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c196_pending_discarded", 32'(cur_delay), 32'd3);
    check("c196_busy", 32'(cfg_busy), 32'd0);
    nxt();

    // Update during flush leaves the block pending once the fill completes.
    step(1'b0, 1'b1, 5'd4);
    step(1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd6);
    repeat (2) step(1'b0, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c204_fill_high", 32'(fill_done), 32'd1);
    check("c204_busy_pending", 32'(cfg_busy), 32'd1);
    check("c204_cur4", 32'(cur_delay), 32'd4);
    nxt();
    repeat (3) step(1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0); neg();
    check("c209_cur6", 32'(cur_delay), 32'd6);
    check("c209_fill_low", 32'(fill_done), 32'd0);
    nxt();
    repeat (10) step(1'b0, 1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_stream_delay.md
Name: cmos_stream_delay

Overview:
- Parametrised delay line for CMOS pixel streams (href, vsync, data) ahead of the write FIFO; the next generation of the fixed 3-cycle delay.
- Width and maximum depth are generic; the delay is programmable at runtime and changes only at a frame boundary.
- Output is blanked while the pipeline refills after reset or a delay change, so downstream logic never sees stale or garbage samples.

Parameters:
- DATA_WIDTH, 8: pixel data width.
- MAX_DELAY, 16: maximum delay in cycles; also the circular buffer depth; ≥1.
- DLY_W, 5: width of the delay fields; must hold MAX_DELAY.
- DEFAULT_DELAY, 3: delay in effect after reset; ≤MAX_DELAY.

Ports:
- cmos_pclk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmos_href  in  1  line valid.
- cmos_vsync  in  1  frame sync, active-high.
- cmos_data  in  DATA_WIDTH  pixel data.
- cfg_delay  in  DLY_W  requested delay.
- cfg_update  in  1  single-cycle strobe; latches cfg_delay.
- cmos_href_delay  out  1  delayed href.
- cmos_vsync_delay  out  1  delayed vsync.
- cmos_data_delay  out  DATA_WIDTH  delayed data.
- cur_delay  out  DLY_W  delay currently applied.
- cfg_busy  out  1  high while a delay change is pending or flushing.
- fill_done  out  1  high when the outputs carry valid delayed samples.

Behaviour:
- Reset (rst_n low at an edge): wr_ptr=0, cur_delay=DEFAULT_DELAY, fill_cnt=0, state=IDLE, pending=0, vsync_prev=0. While rst_n is low, all outputs are forced 0 (cfg_busy=0, fill_done=0). Buffer contents are don't-care.
- Buffer: MAX_DELAY entries of {vsync, href, data}. Every cycle it writes the inputs at wr_ptr, then wr_ptr increments and wraps MAX_DELAY-1 to 0.
- Read path:
  - For d=cur_delay ≥1, the outputs are the entry at (wr_ptr - d) mod MAX_DELAY, which is the input sampled exactly d edges earlier.
  - d=0 is a combinational bypass.
- Gating: while fill_done=0, href, vsync and data outputs are 0.
  - fill_cnt increments per cycle, saturating at cur_delay.
  - fill_done = (fill_cnt == cur_delay).
  - With d=0, fill_done is high immediately.
- cfg_delay > MAX_DELAY is saturated to MAX_DELAY when latched.
- Frame edge: vsync_rise = cmos_vsync & ~vsync_prev, detected on the input side.
- FSM:
  - IDLE: cfg_update latches pending and moves to PENDING. A vsync_rise in the same cycle does not apply the change; it waits for the next frame.
  - PENDING: a further cfg_update overwrites pending. On vsync_rise, cur_delay takes pending; if cfg_update coincides with vsync_rise, the concurrent cfg_delay wins. Then fill_cnt=0 and the FSM moves to FLUSH.
  - FLUSH: outputs gated. When fill_cnt reaches cur_delay, go to IDLE. A cfg_update during FLUSH latches pending; on flush completion the FSM goes to PENDING instead of IDLE.
- cfg_busy = (state != IDLE).
- Reset mid-operation: pending is discarded and the FSM returns to IDLE with DEFAULT_DELAY.

Optional Feature:
- Macro CMOS_DELAY_EDGE_OUT_EN.
- Defined: adds outputs vsync_rise_o and vsync_fall_o (1 bit each). These are one-cycle pulses on the rising and falling edges of gated cmos_vsync_delay, registered (one cycle after the edge appears on cmos_vsync_delay), and 0 in reset.
- Undefined: the ports and logic are absent; other behaviour is identical.

Test Plan:
- Reset release, defaults, ramp data 0x00,0x01,… with href=1 → outputs 0 for 3 cycles, then fill_done=1 and cmos_data_delay lags the input by exactly 3 (input 0x05 appears 3 edges later). Matches the legacy fixed delay.
- cfg_delay=7 with cfg_update mid-frame → cur_delay stays 3 and cfg_busy=1 until the next vsync rise. Then outputs are 0 for 7 cycles, fill_done returns at count 7, and the lag is 7; cfg_busy drops with fill_done.
- cfg_delay=31 (MAX_DELAY=16) → cur_delay=16 after the frame edge, and the lag is 16 with wr_ptr wrapping correctly over 100+ cycles.
- cfg_delay=0 → after the vsync rise, outputs equal the inputs in the same cycle and fill_done=1.
- cfg_update=5 in IDLE coincident with a vsync rise, then cfg_update=9 coincident with the next rise → 5 is never applied; cur_delay=9 after the second rise.
- rst_n low for 1 cycle during FLUSH → all outputs 0, then cur_delay=3 and cfg_busy=0, with a normal 3-cycle fill.
